// File: rtl/matrix_issue_ctrl_pkg.sv
// Shared matrix-ISA types for the tensor-core issue path: register/word widths,
// opcodes, the queued-op record and the issue-controller state encoding.
package matrix_issue_ctrl_pkg;

  localparam int MATRIX_W = 6;
  localparam int NMAT     = 2**MATRIX_W;
  localparam int WORD_W   = 32;

  typedef logic [MATRIX_W-1:0] matbits_t;
  typedef logic [WORD_W-1:0]   word_t;

  typedef enum logic [2:0] {
    RTYPE = 3'd0,
    LD_M  = 3'd1,
    ST_M  = 3'd2,
    GEMM  = 3'd3,
    HALT  = 3'd4
  } opcode_t;

  typedef struct packed {
    opcode_t  opcode;
    matbits_t md;
    matbits_t ms1;
    matbits_t ms2;
    matbits_t ms3;
  } mat_op_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/mat_op_fifo.sv
// In-order queue of issued matrix ops. Every slot is exposed with its valid
// bit so the issue logic can build the read set of all in-flight sources.
module mat_op_fifo
  import matrix_issue_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  mat_op_t            push_data,
  output logic               full,
  output logic               empty,
  output mat_op_t            head,
  output logic [DEPTH-1:0]   entry_valid,
  output mat_op_t            entry_data [DEPTH]
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [DEPTH-1:0] valid_reg;
  mat_op_t          mem_reg [DEPTH];

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Push never lands on the slot being popped: push needs a free slot and pop
  // needs an occupied one, so per-slot valid bits fully describe occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      valid_reg  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      if (pop) begin
        valid_reg[rd_ptr_reg] <= 1'b0;
        rd_ptr_reg            <= ptr_inc(rd_ptr_reg);
      end
      if (push) begin
        valid_reg[wr_ptr_reg] <= 1'b1;
        mem_reg[wr_ptr_reg]   <= push_data;
        wr_ptr_reg            <= ptr_inc(wr_ptr_reg);
      end
    end
  end

  assign full        = &valid_reg;
  assign empty       = ~|valid_reg;
  assign head        = mem_reg[rd_ptr_reg];
  assign entry_valid = valid_reg;
  assign entry_data  = mem_reg;

endmodule

// File: rtl/matrix_issue_ctrl.sv
// Matrix instruction issue controller: hazard scoreboard over the matrix
// registers, per-unit in-order tracking queues and a HALT drain sequence.
module matrix_issue_ctrl
  import matrix_issue_ctrl_pkg::*;
#(
  parameter int LS_DEPTH   = 2,
  parameter int GEMM_DEPTH = 2
) (
  input  logic     CLK,
  input  logic     RST,
  input  logic     instr_valid,
  output logic     instr_ready,
  input  opcode_t  opcode,
  input  matbits_t md,
  input  matbits_t ms1,
  input  matbits_t ms2,
  input  matbits_t ms3,
  input  word_t    base_addr,
  input  word_t    stride,
  output logic     ls_req,
  input  logic     ls_ready,
  output logic     ls_is_store,
  output matbits_t ls_mreg,
  output word_t    ls_addr,
  output word_t    ls_stride,
  input  logic     ls_done,
  output logic     gemm_req,
  input  logic     gemm_ready,
  output matbits_t gemm_md,
  output matbits_t gemm_ms1,
  output matbits_t gemm_ms2,
  output matbits_t gemm_ms3,
  input  logic     gemm_done,
  output logic     halted,
  output logic     err
);

  ctrl_state_t state_reg, state_next;
  logic [NMAT-1:0] wr_busy_reg, wr_busy_next;
  logic [NMAT-1:0] read_set;
  logic            err_reg;
  logic            run;

  logic ls_full, ls_empty, gemm_full, gemm_empty;
  logic ls_push, ls_pop, gemm_push, gemm_pop;
  logic [LS_DEPTH-1:0]   ls_valid;
  logic [GEMM_DEPTH-1:0] gemm_valid;
  mat_op_t ls_data [LS_DEPTH];
  mat_op_t gemm_data [GEMM_DEPTH];
  mat_op_t ls_head, gemm_head, new_op;

  logic is_ls, is_gemm, has_dst, raw, dst_conflict, hazard_free;
  logic halt_accept, bad_accept;

  assign new_op = '{opcode: opcode, md: md, ms1: ms1, ms2: ms2, ms3: ms3};

  mat_op_fifo #(.DEPTH(LS_DEPTH)) u_ls_fifo (
    .clk(CLK), .rst(RST), .push(ls_push), .pop(ls_pop), .push_data(new_op),
    .full(ls_full), .empty(ls_empty), .head(ls_head),
    .entry_valid(ls_valid), .entry_data(ls_data)
  );

  mat_op_fifo #(.DEPTH(GEMM_DEPTH)) u_gemm_fifo (
    .clk(CLK), .rst(RST), .push(gemm_push), .pop(gemm_pop), .push_data(new_op),
    .full(gemm_full), .empty(gemm_empty), .head(gemm_head),
    .entry_valid(gemm_valid), .entry_data(gemm_data)
  );

  // Registers still to be read by in-flight stores and GEMMs (WAR guard).
  always_comb begin
    read_set = '0;
    for (int i = 0; i < LS_DEPTH; i++)
      if (ls_valid[i] && ls_data[i].opcode == ST_M) read_set[ls_data[i].md] = 1'b1;
    for (int i = 0; i < GEMM_DEPTH; i++)
      if (gemm_valid[i]) begin
        read_set[gemm_data[i].ms1] = 1'b1;
        read_set[gemm_data[i].ms2] = 1'b1;
        read_set[gemm_data[i].ms3] = 1'b1;
      end
  end

  assign is_ls        = (opcode == LD_M) || (opcode == ST_M);
  assign is_gemm      = (opcode == GEMM);
  assign has_dst      = (opcode == LD_M) || is_gemm;
  assign raw          = ((opcode == ST_M) && wr_busy_reg[md]) ||
                        (is_gemm && (wr_busy_reg[ms1] || wr_busy_reg[ms2] || wr_busy_reg[ms3]));
  assign dst_conflict = has_dst && (wr_busy_reg[md] || read_set[md]);
  assign hazard_free  = !raw && !dst_conflict;

  assign ls_req      = instr_valid && is_ls   && hazard_free && !ls_full   && run;
  assign gemm_req    = instr_valid && is_gemm && hazard_free && !gemm_full && run;
  assign halt_accept = instr_valid && (opcode == HALT) && run;
  assign bad_accept  = instr_valid && !is_ls && !is_gemm && (opcode != HALT) && run;
  assign instr_ready = (ls_req && ls_ready) || (gemm_req && gemm_ready) || halt_accept || bad_accept;

  assign ls_push   = ls_req && ls_ready;
  assign gemm_push = gemm_req && gemm_ready;
  assign ls_pop    = ls_done && !ls_empty;
  assign gemm_pop  = gemm_done && !gemm_empty;

  assign ls_is_store = ls_req && (opcode == ST_M);
  assign ls_mreg     = ls_req ? md : '0;
  assign ls_addr     = ls_req ? base_addr : '0;
  assign ls_stride   = ls_req ? stride : '0;
  assign gemm_md     = gemm_req ? md  : '0;
  assign gemm_ms1    = gemm_req ? ms1 : '0;
  assign gemm_ms2    = gemm_req ? ms2 : '0;
  assign gemm_ms3    = gemm_req ? ms3 : '0;

  // Clears and the set always target different registers, so order is moot.
  always_comb begin
    wr_busy_next = wr_busy_reg;
    if (ls_pop && ls_head.opcode == LD_M) wr_busy_next[ls_head.md] = 1'b0;
    if (gemm_pop) wr_busy_next[gemm_head.md] = 1'b0;
    if ((ls_push || gemm_push) && has_dst) wr_busy_next[md] = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_busy_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      wr_busy_reg <= wr_busy_next;
      if ((ls_done && ls_empty) || (gemm_done && gemm_empty) || bad_accept)
        err_reg <= 1'b1;
    end
  end

  assign err = err_reg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_reg <= RUN;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (halt_accept) state_next = DRAIN;
      DRAIN:   if (ls_empty && gemm_empty) state_next = HALTED;
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    run    = 1'b0;
    halted = 1'b0;
    case (state_reg)
      RUN:     run = 1'b1;
      HALTED:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_matrix_issue_ctrl.sv
// Directed bench for matrix_issue_ctrl: expected issues are queued when an op
// is driven and matched against the unit interface when the DUT issues it.
module tb_matrix_issue_ctrl;
  import matrix_issue_ctrl_pkg::*;

  logic     CLK = 1'b0;
  logic     RST;
  logic     instr_valid, instr_ready;
  opcode_t  opcode;
  matbits_t md, ms1, ms2, ms3;
  word_t    base_addr, stride;
  logic     ls_req, ls_ready, ls_is_store, ls_done;
  matbits_t ls_mreg;
  word_t    ls_addr, ls_stride;
  logic     gemm_req, gemm_ready, gemm_done;
  matbits_t gemm_md, gemm_ms1, gemm_ms2, gemm_ms3;
  logic     halted, err;

  matrix_issue_ctrl #(.LS_DEPTH(2), .GEMM_DEPTH(2)) dut (
    .CLK(CLK), .RST(RST),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .opcode(opcode),
    .md(md), .ms1(ms1), .ms2(ms2), .ms3(ms3),
    .base_addr(base_addr), .stride(stride),
    .ls_req(ls_req), .ls_ready(ls_ready), .ls_is_store(ls_is_store),
    .ls_mreg(ls_mreg), .ls_addr(ls_addr), .ls_stride(ls_stride), .ls_done(ls_done),
    .gemm_req(gemm_req), .gemm_ready(gemm_ready),
    .gemm_md(gemm_md), .gemm_ms1(gemm_ms1), .gemm_ms2(gemm_ms2), .gemm_ms3(gemm_ms3),
    .gemm_done(gemm_done), .halted(halted), .err(err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit       is_ls;
    bit       is_store;
    matbits_t md, ms1, ms2, ms3;
    word_t    addr, stride;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_op(opcode_t op, matbits_t d, matbits_t s1, matbits_t s2, matbits_t s3);
    instr_valid = 1'b1;
    opcode = op; md = d; ms1 = s1; ms2 = s2; ms3 = s3;
    base_addr = 32'h1000 + 32'(d);
    stride    = 32'h40 + 32'(s1);
  endtask

  task automatic expect_issue();
    exp_t e;
    e.is_ls    = (opcode == LD_M) || (opcode == ST_M);
    e.is_store = (opcode == ST_M);
    e.md = md; e.ms1 = ms1; e.ms2 = ms2; e.ms3 = ms3;
    e.addr = base_addr; e.stride = stride;
    exp_q.push_back(e);
  endtask

  // One clock cycle with the currently driven inputs; samples on the falling edge.
  task automatic cyc(string tag, bit exp_ready);
    bit op_ls, op_gemm;
    exp_t e;
    op_ls   = instr_valid && ((opcode == LD_M) || (opcode == ST_M));
    op_gemm = instr_valid && (opcode == GEMM);
    @(negedge CLK);
    chk({tag, ".instr_ready"}, 64'(instr_ready), 64'(exp_ready));
    chk({tag, ".ls_req"},      64'(ls_req),      64'(exp_ready && op_ls));
    chk({tag, ".gemm_req"},    64'(gemm_req),    64'(exp_ready && op_gemm));
    if ((ls_req && ls_ready) || (gemm_req && gemm_ready)) begin
      if (exp_q.size() == 0) begin
        chk({tag, ".unexpected_issue"}, 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk({tag, ".unit_is_ls"}, 64'(ls_req), 64'(e.is_ls));
        if (e.is_ls) begin
          chk({tag, ".ls_mreg"},     64'(ls_mreg),     64'(e.md));
          chk({tag, ".ls_is_store"}, 64'(ls_is_store), 64'(e.is_store));
          chk({tag, ".ls_addr"},     64'(ls_addr),     64'(e.addr));
          chk({tag, ".ls_stride"},   64'(ls_stride),   64'(e.stride));
        end else begin
          chk({tag, ".gemm_md"},  64'(gemm_md),  64'(e.md));
          chk({tag, ".gemm_ms1"}, 64'(gemm_ms1), 64'(e.ms1));
          chk({tag, ".gemm_ms2"}, 64'(gemm_ms2), 64'(e.ms2));
          chk({tag, ".gemm_ms3"}, 64'(gemm_ms3), 64'(e.ms3));
        end
      end
    end
    $display("t=%0t %s valid=%b op=%s ready=%b ls_req=%b gemm_req=%b ls_done=%b gemm_done=%b",
             $time, tag, instr_valid, opcode.name(), instr_ready, ls_req, gemm_req, ls_done, gemm_done);
    @(posedge CLK);
    #1;
    ls_done   = 1'b0;
    gemm_done = 1'b0;
  endtask

  task automatic issue(string tag, opcode_t op, matbits_t d, matbits_t s1, matbits_t s2, matbits_t s3);
    set_op(op, d, s1, s2, s3);
    expect_issue();
    cyc(tag, 1'b1);
    instr_valid = 1'b0;
  endtask

  task automatic idle(string tag, bit lsd, bit gd);
    instr_valid = 1'b0;
    ls_done     = lsd;
    gemm_done   = gd;
    cyc(tag, 1'b0);
  endtask

  task automatic reset_pulse();
    RST = 1'b1;
    #2;
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    instr_valid = 1'b0; opcode = RTYPE; md = '0; ms1 = '0; ms2 = '0; ms3 = '0;
    base_addr = '0; stride = '0;
    ls_ready = 1'b1; gemm_ready = 1'b1; ls_done = 1'b0; gemm_done = 1'b0;

    @(negedge CLK);
    chk("rst.instr_ready", 64'(instr_ready), 64'd0);
    chk("rst.ls_req",      64'(ls_req),      64'd0);
    chk("rst.gemm_req",    64'(gemm_req),    64'd0);
    chk("rst.halted",      64'(halted),      64'd0);
    chk("rst.err",         64'(err),         64'd0);
    chk("rst.ls_mreg",     64'(ls_mreg),     64'd0);
    chk("rst.gemm_md",     64'(gemm_md),     64'd0);
    @(posedge CLK); #1;
    RST = 1'b0;

    // Single load, then a GEMM reading it: blocked until the cycle after ls_done.
    issue("ld5", LD_M, 6'd5, 6'd0, 6'd0, 6'd0);
    set_op(GEMM, 6'd9, 6'd5, 6'd6, 6'd6);
    cyc("raw_m5", 1'b0);
    ls_done = 1'b1;
    cyc("raw_m5_done_no_bypass", 1'b0);
    expect_issue();
    cyc("gemm9", 1'b1);
    instr_valid = 1'b0;
    idle("gemm9_done", 1'b0, 1'b1);

    // RAW from the test plan: GEMM md=7 ms1=3 behind LD_M m3.
    issue("ld3", LD_M, 6'd3, 6'd0, 6'd0, 6'd0);
    set_op(GEMM, 6'd7, 6'd3, 6'd8, 6'd8);
    cyc("raw_m3_a", 1'b0);
    cyc("raw_m3_b", 1'b0);
    ls_done = 1'b1;
    cyc("raw_m3_done", 1'b0);
    expect_issue();
    cyc("gemm7", 1'b1);
    instr_valid = 1'b0;
    idle("gemm7_done", 1'b0, 1'b1);

    // WAR / WAW against GEMM md=1 ms1=2; independent LD_M m4 goes straight through.
    issue("gemm1", GEMM, 6'd1, 6'd2, 6'd2, 6'd2);
    set_op(LD_M, 6'd2, 6'd0, 6'd0, 6'd0);
    cyc("war_m2", 1'b0);
    set_op(LD_M, 6'd1, 6'd0, 6'd0, 6'd0);
    cyc("waw_m1", 1'b0);
    issue("ld4", LD_M, 6'd4, 6'd0, 6'd0, 6'd0);
    set_op(LD_M, 6'd1, 6'd0, 6'd0, 6'd0);
    gemm_done = 1'b1;
    cyc("waw_m1_done", 1'b0);
    expect_issue();
    cyc("ld1", 1'b1);

    // LS queue now full (m4, m1): a third load stalls, even alongside ls_done.
    set_op(LD_M, 6'd2, 6'd0, 6'd0, 6'd0);
    cyc("ls_full", 1'b0);
    ls_done = 1'b1;
    cyc("ls_full_with_done", 1'b0);
    expect_issue();
    cyc("ld2", 1'b1);
    instr_valid = 1'b0;
    idle("ls_pop_a", 1'b1, 1'b0);
    idle("ls_pop_b", 1'b1, 1'b0);

    // Store: RAW on a pending load, then WAR protects the stored register.
    issue("ld20", LD_M, 6'd20, 6'd0, 6'd0, 6'd0);
    set_op(ST_M, 6'd20, 6'd0, 6'd0, 6'd0);
    cyc("st_raw", 1'b0);
    ls_done = 1'b1;
    cyc("st_raw_done", 1'b0);
    expect_issue();
    cyc("st20", 1'b1);
    set_op(LD_M, 6'd20, 6'd0, 6'd0, 6'd0);
    cyc("st_war", 1'b0);
    issue("gemm21", GEMM, 6'd21, 6'd20, 6'd22, 6'd23);
    idle("both_done", 1'b1, 1'b1);
    issue("ld20b", LD_M, 6'd20, 6'd0, 6'd0, 6'd0);
    idle("ld20b_done", 1'b1, 1'b0);
    chk("no_err_yet", 64'(err), 64'd0);

    // Drain: two GEMMs in flight, HALT accepted, nothing issues afterwards.
    issue("gemm30", GEMM, 6'd30, 6'd31, 6'd31, 6'd31);
    issue("gemm32", GEMM, 6'd32, 6'd33, 6'd33, 6'd33);
    set_op(HALT, 6'd0, 6'd0, 6'd0, 6'd0);
    cyc("halt", 1'b1);
    set_op(LD_M, 6'd40, 6'd0, 6'd0, 6'd0);
    cyc("drain_block", 1'b0);
    chk("drain.halted", 64'(halted), 64'd0);
    instr_valid = 1'b0;
    idle("drain_done_a", 1'b0, 1'b1);
    chk("drain_a.halted", 64'(halted), 64'd0);
    idle("drain_done_b", 1'b0, 1'b1);
    idle("drain_settle", 1'b0, 1'b0);
    chk("halted", 64'(halted), 64'd1);
    set_op(LD_M, 6'd40, 6'd0, 6'd0, 6'd0);
    cyc("halted_block", 1'b0);
    instr_valid = 1'b0;
    chk("halted_hold", 64'(halted), 64'd1);
    chk("drain.err", 64'(err), 64'd0);

    // Error paths: spurious done, then an unknown opcode.
    reset_pulse();
    chk("rst2.halted", 64'(halted), 64'd0);
    idle("spurious_ls_done", 1'b1, 1'b0);
    chk("spurious.err", 64'(err), 64'd1);
    idle("err_hold_a", 1'b0, 1'b0);
    idle("err_hold_b", 1'b0, 1'b0);
    chk("err_sticky", 64'(err), 64'd1);
    reset_pulse();
    chk("rst3.err", 64'(err), 64'd0);
    set_op(RTYPE, 6'd0, 6'd0, 6'd0, 6'd0);
    cyc("rtype", 1'b1);
    instr_valid = 1'b0;
    chk("rtype.err", 64'(err), 64'd1);

    // Reset in the middle of a drain discards queue and busy state.
    reset_pulse();
    issue("gemm30b", GEMM, 6'd30, 6'd31, 6'd31, 6'd31);
    set_op(HALT, 6'd0, 6'd0, 6'd0, 6'd0);
    cyc("halt2", 1'b1);
    instr_valid = 1'b0;
    RST = 1'b1;
    #1;
    chk("mid_rst.instr_ready", 64'(instr_ready), 64'd0);
    chk("mid_rst.gemm_req",    64'(gemm_req),    64'd0);
    chk("mid_rst.halted",      64'(halted),      64'd0);
    chk("mid_rst.err",         64'(err),         64'd0);
    RST = 1'b0;
    issue("ld30_after_rst", LD_M, 6'd30, 6'd0, 6'd0, 6'd0);
    idle("ld30_done", 1'b1, 1'b0);
    chk("mid_rst.err_after", 64'(err), 64'd0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
